// File: rtl/mc_sequencer_pkg.sv
// Shared encodings for the multicycle control sequencer: FSM states, decoded
// instruction classes and PC source selects.
package mc_sequencer_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    OP_ALU    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_STORE  = 3'd2,
    OP_BRANCH = 3'd3,
    OP_JUMP   = 3'd4,
    OP_CALL   = 3'd5,
    OP_HALT   = 3'd6,
    OP_ILL    = 3'd7
  } op_t;

  localparam logic [1:0] PC_INC = 2'd0;  // pc + 1
  localparam logic [1:0] PC_OFS = 2'd1;  // pc + offset
  localparam logic [1:0] PC_ALU = 2'd2;  // alu result
  localparam logic [1:0] PC_JMP = 2'd3;  // jump target

endpackage

// File: rtl/mc_sequencer_perf_cnt.sv
// Performance counters: retired instructions (wrapping) and memory-wait cycles
// (saturating). Both update one cycle after their increment strobe.
module mc_perf_cnt
  import mc_sequencer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ret_inc,
  input  logic             stall_inc,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] stall_cyc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      retired   <= '0;
      stall_cyc <= '0;
    end else begin
      if (ret_inc)
        retired <= retired + CNT_W'(1);
      if (stall_inc && (stall_cyc != '1))
        stall_cyc <= stall_cyc + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB with req/ack memory handshakes.
// Requests hold until ack; a wait of TIMEOUT cycles raises err and parks in HALT.
module mc_sequencer
  import mc_sequencer_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op_class,
  input  logic             take_branch,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_en,
  output logic             reg_en,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] stall_cyc
);

  state_t          state_q, state_n;
  op_t             op_q, op_dec;
  logic [TO_W-1:0] to_cnt;
  logic            timeout, stall, set_err, halt_ret, err_q;

  assign op_dec  = op_t'(op_class);
  assign timeout = (TIMEOUT != 0) && (to_cnt == TO_W'(TIMEOUT - 1));
  assign state   = state_q;
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= OP_ALU;
      to_cnt  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      err_q   <= err_q | set_err;
      if (state_q == S_DECODE)
        op_q <= op_dec;
      // Wait counter restarts whenever a new state (FETCH or MEM) is entered.
      if (state_n != state_q)
        to_cnt <= '0;
      else if (stall)
        to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_comb begin
    state_n  = state_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_en    = 1'b0;
    reg_en   = 1'b0;
    pc_en    = 1'b0;
    pc_sel   = PC_INC;
    halted   = 1'b0;
    stall    = 1'b0;
    set_err  = 1'b0;
    halt_ret = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_en   = 1'b1;
          state_n = S_DECODE;
        end else begin
          stall = 1'b1;
          if (timeout) begin
            set_err = 1'b1;
            state_n = S_HALT;
          end
        end
      end
      S_DECODE: begin
        unique case (op_dec)
          OP_JUMP: begin
            pc_en   = 1'b1;
            pc_sel  = PC_JMP;
            state_n = S_FETCH;
          end
          OP_CALL: state_n = S_WB;
          OP_HALT: begin
            halt_ret = 1'b1;
            state_n  = S_HALT;
          end
          OP_ILL: begin
            set_err = 1'b1;
            state_n = S_HALT;
          end
          default: state_n = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (op_q)
          OP_ALU:            state_n = S_WB;
          OP_LOAD, OP_STORE: state_n = S_MEM;
          OP_BRANCH: begin
            pc_en   = 1'b1;
            pc_sel  = take_branch ? PC_OFS : PC_INC;
            state_n = S_FETCH;
          end
          default:           state_n = S_FETCH;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_STORE);
        if (dmem_ack) begin
          if (op_q == OP_STORE) begin
            pc_en   = 1'b1;
            state_n = S_FETCH;
          end else begin
            state_n = S_WB;
          end
        end else begin
          stall = 1'b1;
          if (timeout) begin
            set_err = 1'b1;
            state_n = S_HALT;
          end
        end
      end
      S_WB: begin
        reg_en  = 1'b1;
        pc_en   = 1'b1;
        pc_sel  = (op_q == OP_CALL) ? PC_JMP : PC_INC;
        state_n = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_n = S_FETCH;
    endcase
  end

  mc_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .clk       (clk),
    .rst       (rst),
    .ret_inc   (pc_en | halt_ret),
    .stall_inc (stall),
    .retired   (retired),
    .stall_cyc (stall_cyc)
  );

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized bench for mc_sequencer: expected per-cycle traces are built from the
// instruction-class rules, plus counter/err bookkeeping per retired instruction.
`timescale 1ns/1ps
module tb_mc_sequencer;

  localparam int CNT_W   = 6;
  localparam int TIMEOUT = 4;
  localparam int TO_W    = 3;
  localparam int MAXC    = (1 << CNT_W) - 1;
  localparam logic [2:0] FE = 3'd0, DE = 3'd1, EX = 3'd2, ME = 3'd3, WBS = 3'd4, HA = 3'd5;

  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] op_class = 3'd0;
  logic take_branch = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic imem_req, dmem_req, dmem_we, ir_en, reg_en, pc_en, halted, err;
  logic [1:0] pc_sel;
  logic [2:0] state;
  logic [CNT_W-1:0] retired, stall_cyc;

  typedef struct packed {
    logic [2:0] st;
    logic ireq, dreq, we, ir, rg, pc;
    logic [1:0] sel;
    logic hlt;
  } exp_t;

  int n_tests = 0, n_fail = 0;
  int m_ret = 0, m_stall = 0;
  bit m_err = 0;

  always #5 clk = ~clk;

  mc_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .op_class(op_class), .take_branch(take_branch),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .ir_en(ir_en), .reg_en(reg_en), .pc_en(pc_en), .pc_sel(pc_sel),
    .state(state), .halted(halted), .err(err), .retired(retired), .stall_cyc(stall_cyc)
  );

  function automatic exp_t blank(input logic [2:0] st);
    exp_t e = '0;
    e.st  = st;
    e.hlt = (st == HA);
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.st = state; o.ireq = imem_req; o.dreq = dmem_req; o.we = dmem_we;
    o.ir = ir_en; o.rg = reg_en; o.pc = pc_en; o.sel = pc_sel; o.hlt = halted;
    return o;
  endfunction

  // Entered and left just after a falling edge.
  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_ret = 0; m_stall = 0; m_err = 0;
  endtask

  // Runs one instruction: di cycles of imem wait, dd cycles of dmem wait.
  task automatic run_instr(input string tag, input int op, input bit br, input int di, input int dd);
    exp_t q[$];
    bit ak[$];
    exp_t e, o;
    bit to_halt = 0, go_exec = 0, go_mem = 0, go_wb = 0, new_err = 0;
    logic [1:0] wb_sel = 2'd0;
    int rets = 0, stalls = 0;
    logic [2:0] end_st;
    for (int i = 0; i < di && i < TIMEOUT; i++) begin
      e = blank(FE); e.ireq = 1; q.push_back(e); ak.push_back(0); stalls++;
    end
    if (di >= TIMEOUT) begin
      to_halt = 1; new_err = 1;
    end else begin
      e = blank(FE); e.ireq = 1; e.ir = 1; q.push_back(e); ak.push_back(1);
      e = blank(DE);
      case (op)
        4: begin e.pc = 1; e.sel = 2'd3; rets++; end
        5: begin go_wb = 1; wb_sel = 2'd3; end
        6: begin to_halt = 1; rets++; end
        7: begin to_halt = 1; new_err = 1; end
        default: go_exec = 1;
      endcase
      q.push_back(e); ak.push_back(0);
    end
    if (go_exec) begin
      e = blank(EX);
      if (op == 0) go_wb = 1;
      else if (op == 3) begin e.pc = 1; e.sel = br ? 2'd1 : 2'd0; rets++; end
      else go_mem = 1;
      q.push_back(e); ak.push_back(0);
    end
    if (go_mem) begin
      for (int i = 0; i < dd && i < TIMEOUT; i++) begin
        e = blank(ME); e.dreq = 1; e.we = (op == 2); q.push_back(e); ak.push_back(0); stalls++;
      end
      if (dd >= TIMEOUT) begin
        to_halt = 1; new_err = 1;
      end else begin
        e = blank(ME); e.dreq = 1; e.we = (op == 2);
        if (op == 2) begin e.pc = 1; rets++; end
        else go_wb = 1;
        q.push_back(e); ak.push_back(1);
      end
    end
    if (go_wb) begin
      e = blank(WBS); e.rg = 1; e.pc = 1; e.sel = wb_sel; q.push_back(e); ak.push_back(0); rets++;
    end

    for (int c = 0; c < q.size(); c++) begin
      op_class    = (q[c].st == DE) ? 3'(op) : 3'($urandom_range(0, 7));
      take_branch = (q[c].st == EX) ? br : 1'($urandom_range(0, 1));
      imem_ack    = (q[c].st == FE) ? ak[c] : 1'($urandom_range(0, 1));
      dmem_ack    = (q[c].st == ME) ? ak[c] : 1'($urandom_range(0, 1));
      #1;
      o = observe();
      n_tests++;
      if (o !== q[c]) begin
        n_fail++;
        $display("FAIL %s op%0d cyc%0d outputs got %h want %h", tag, op, c, o, q[c]);
      end
      @(negedge clk);
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;

    m_ret   = (m_ret + rets) % (MAXC + 1);
    m_stall = (m_stall + stalls > MAXC) ? MAXC : m_stall + stalls;
    m_err   = m_err | new_err;
    end_st  = to_halt ? HA : FE;
    n_tests++;
    if (state !== end_st) begin n_fail++; $display("FAIL %s end_state got %0d want %0d", tag, state, end_st); end
    n_tests++;
    if (err !== m_err) begin n_fail++; $display("FAIL %s err got %0b want %0b", tag, err, m_err); end
    n_tests++;
    if (retired !== CNT_W'(m_ret)) begin n_fail++; $display("FAIL %s retired got %0d want %0d", tag, retired, m_ret); end
    n_tests++;
    if (stall_cyc !== CNT_W'(m_stall)) begin n_fail++; $display("FAIL %s stall_cyc got %0d want %0d", tag, stall_cyc, m_stall); end
  endtask

  // Stays in HALT regardless of acks; counters and err frozen.
  task automatic hold_halt(input string tag, input int n);
    exp_t o;
    for (int c = 0; c < n; c++) begin
      op_class = 3'($urandom_range(0, 7)); take_branch = 1'($urandom_range(0, 1));
      imem_ack = 1'($urandom_range(0, 1)); dmem_ack = 1'($urandom_range(0, 1));
      #1;
      o = observe();
      n_tests++;
      if (o !== blank(HA)) begin n_fail++; $display("FAIL %s halt cyc%0d got %h want %h", tag, c, o, blank(HA)); end
      @(negedge clk);
    end
    n_tests++;
    if (retired !== CNT_W'(m_ret) || stall_cyc !== CNT_W'(m_stall) || err !== m_err) begin
      n_fail++;
      $display("FAIL %s halt_frozen got ret%0d stall%0d err%0b want ret%0d stall%0d err%0b",
               tag, retired, stall_cyc, err, m_ret, m_stall, m_err);
    end
  endtask

  task automatic test_reset();
    exp_t o, e;
    do_reset();
    #1;
    o = observe(); e = blank(FE); e.ireq = 1;
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL reset outputs got %h want %h", o, e); end
    n_tests++;
    if (retired !== '0 || stall_cyc !== '0 || err !== 1'b0) begin
      n_fail++; $display("FAIL reset counters got ret%0d stall%0d err%0b want 0 0 0", retired, stall_cyc, err);
    end
  endtask

  task automatic test_alu();
    run_instr("alu", 0, 0, 0, 0);
  endtask

  task automatic test_load_wait();
    run_instr("load_wait", 1, 0, 0, 3);
  endtask

  task automatic test_branch();
    run_instr("branch_taken", 3, 1, 0, 0);
    run_instr("branch_not", 3, 0, 0, 0);
  endtask

  task automatic test_store_call_jump();
    run_instr("store", 2, 0, 1, 2);
    run_instr("call", 5, 0, 2, 0);
    run_instr("jump", 4, 0, 0, 0);
  endtask

  task automatic test_halt_op();
    run_instr("halt_op", 6, 0, 1, 0);
    hold_halt("halt_op", 4);
    do_reset();
  endtask

  task automatic test_illegal();
    run_instr("illegal", 7, 0, 0, 0);
    hold_halt("illegal", 5);
    do_reset();
    #1;
    n_tests++;
    if (state !== FE || err !== 1'b0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL illegal_rst got state%0d err%0b halted%0b want 0 0 0", state, err, halted);
    end
  endtask

  task automatic test_timeout();
    run_instr("fetch_timeout", 0, 0, TIMEOUT + 3, 0);
    hold_halt("fetch_timeout", 3);
    do_reset();
    run_instr("mem_timeout", 2, 0, 0, TIMEOUT + 5);
    hold_halt("mem_timeout", 3);
    do_reset();
  endtask

  task automatic test_rst_mid();
    run_instr("pre_mid", 0, 0, 1, 0);
    imem_ack = 1'b1; @(negedge clk);
    imem_ack = 1'b0; op_class = 3'd1; @(negedge clk);
    op_class = 3'd5; @(negedge clk);
    dmem_ack = 1'b0; #1;
    n_tests++;
    if (dmem_req !== 1'b1 || state !== ME) begin
      n_fail++; $display("FAIL rst_mid pre got state%0d dmem_req%0b want 3 1", state, dmem_req);
    end
    rst = 1'b1; @(negedge clk);
    rst = 1'b0; m_ret = 0; m_stall = 0; m_err = 0;
    #1;
    n_tests++;
    if (state !== FE || dmem_req !== 1'b0 || imem_req !== 1'b1 || retired !== '0 || stall_cyc !== '0) begin
      n_fail++;
      $display("FAIL rst_mid post got state%0d dreq%0b ireq%0b ret%0d stall%0d want 0 0 1 0 0",
               state, dmem_req, imem_req, retired, stall_cyc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 160; i++)
      run_instr("random", int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    run_instr("random_halt", 6, 0, 0, 0);
    hold_halt("random_halt", 2);
    do_reset();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_branch();
    test_store_call_jump();
    test_halt_op();
    test_illegal();
    test_timeout();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
